// File: rtl/sorted_insert_queue.sv
`default_nettype none
// ============================================================================
// sorted_insert_queue : one-cycle sorted insert/pop priority queue (stable ties)
// Rev 1.0
// ============================================================================
module sorted_insert_queue #(
  parameter int depth      = 8,
  parameter int data_sz    = 4,
  parameter int comparator = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_valid,
  input  logic [data_sz-1:0]           push_data,
  output logic                         push_ready,
  output logic                         pop_valid,
  output logic [data_sz-1:0]           pop_data,
  input  logic                         pop_ready,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int               CNT_W   = $clog2(depth+1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(depth);

  logic [data_sz-1:0] r_slot [depth];
  logic [CNT_W-1:0]   r_count;

  logic               w_push_fire;
  logic               w_pop_fire;
  logic [data_sz-1:0] w_base [depth];
  logic [CNT_W-1:0]   w_base_count;
  logic [depth-1:0]   w_worse;
  logic [data_sz-1:0] w_next [depth];

  assign count      = r_count;
  assign full       = (r_count == DEPTH_C);
  assign empty      = (r_count == '0);
  assign push_ready = !full;
  assign pop_valid  = !empty;
  assign pop_data   = r_slot[0];

  always_comb begin
    w_push_fire  = push_valid && !full;
    w_pop_fire   = pop_valid && pop_ready;
    w_base_count = r_count - CNT_W'(w_pop_fire);

    // Post-pop view of the array: insertion is searched over what remains.
    for (int i = 0; i < depth - 1; i++) begin
      w_base[i] = w_pop_fire ? r_slot[i+1] : r_slot[i];
    end
    w_base[depth-1] = r_slot[depth-1];

    // Strictly-worse mask; equal entries stay ahead of the new one.
    for (int i = 0; i < depth; i++) begin
      if (comparator == 0) begin
        w_worse[i] = (CNT_W'(i) < w_base_count) && (w_base[i] > push_data);
      end else begin
        w_worse[i] = (CNT_W'(i) < w_base_count) && (w_base[i] < push_data);
      end
    end

    w_next[0] = (w_push_fire && (w_worse[0] || (w_base_count == '0)))
                ? push_data : w_base[0];
    for (int i = 1; i < depth; i++) begin
      if (!w_push_fire) begin
        w_next[i] = w_base[i];
      end else if (w_worse[i-1]) begin
        w_next[i] = w_base[i-1];
      end else if (w_worse[i] || (CNT_W'(i) == w_base_count)) begin
        w_next[i] = push_data;
      end else begin
        w_next[i] = w_base[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(w_push_fire) - CNT_W'(w_pop_fire);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < depth; i++) begin
      r_slot[i] <= w_next[i];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sorted_insert_queue.sv
`default_nettype none
// Bench for sorted_insert_queue: directed vector table, corner sequences and
// a randomized comparison against a sorted-list model.
module tb_sorted_insert_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pv0, pr0, pv1, pr1;
  logic [3:0] pd0, pd1;
  logic       prdy0, pval0, full0, empty0;
  logic       prdy1, pval1, full1, empty1;
  logic [3:0] pdat0, pdat1;
  logic [3:0] cnt0, cnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sorted_insert_queue #(.depth(8), .data_sz(4), .comparator(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .push_valid(pv0), .push_data(pd0),
    .push_ready(prdy0), .pop_valid(pval0), .pop_data(pdat0),
    .pop_ready(pr0), .count(cnt0), .full(full0), .empty(empty0));

  sorted_insert_queue #(.depth(8), .data_sz(4), .comparator(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .push_valid(pv1), .push_data(pd1),
    .push_ready(prdy1), .pop_valid(pval1), .pop_data(pdat1),
    .pop_ready(pr1), .count(cnt1), .full(full1), .empty(empty1));

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk0(input string tag, input int n, input int head);
    chk({tag, " count"}, int'(cnt0), n);
    chk({tag, " empty"}, int'(empty0), int'(n == 0));
    chk({tag, " full"}, int'(full0), int'(n == 8));
    chk({tag, " pop_valid"}, int'(pval0), int'(n != 0));
    chk({tag, " push_ready"}, int'(prdy0), int'(n != 8));
    if (head >= 0) chk({tag, " head"}, int'(pdat0), head);
  endtask

  typedef struct {
    bit rst_n;
    bit pv;
    int pd;
    bit pr;
    int cnt;
    int head;
  } vec_t;

  vec_t vt[24];

  int mk[$];
  int mt[$];

  initial begin
    rst_n = 1'b0; pv0 = 0; pr0 = 0; pd0 = 0; pv1 = 0; pr1 = 0; pd1 = 0;
    step(); step();
    chk0("reset", 0, -1);
    chk("reset dut1 empty", int'(empty1), 1);
    rst_n = 1'b1;

    // {rst_n, push_valid, push_data, pop_ready, exp count, exp head}
    vt[0]  = '{1, 1, 5,  0, 1, 5};
    vt[1]  = '{1, 1, 2,  0, 2, 2};
    vt[2]  = '{1, 1, 9,  0, 3, 2};
    vt[3]  = '{1, 1, 2,  0, 4, 2};
    vt[4]  = '{1, 1, 7,  0, 5, 2};
    vt[5]  = '{1, 0, 0,  1, 4, 2};
    vt[6]  = '{1, 0, 0,  1, 3, 5};
    vt[7]  = '{1, 0, 0,  1, 2, 7};
    vt[8]  = '{1, 0, 0,  1, 1, 9};
    vt[9]  = '{1, 0, 0,  1, 0, -1};
    vt[10] = '{1, 1, 4,  0, 1, 4};
    vt[11] = '{1, 1, 6,  0, 2, 4};
    vt[12] = '{1, 1, 10, 0, 3, 4};
    vt[13] = '{1, 1, 8,  1, 3, 6};
    vt[14] = '{1, 0, 0,  1, 2, 8};
    vt[15] = '{1, 0, 0,  1, 1, 10};
    vt[16] = '{1, 0, 0,  1, 0, -1};
    vt[17] = '{1, 1, 1,  0, 1, 1};
    vt[18] = '{1, 1, 3,  0, 2, 1};
    vt[19] = '{1, 1, 0,  1, 2, 0};
    vt[20] = '{0, 1, 5,  1, 0, -1};
    vt[21] = '{1, 0, 0,  1, 0, -1};
    vt[22] = '{1, 1, 0,  1, 1, 0};
    vt[23] = '{1, 0, 0,  1, 0, -1};

    for (int i = 0; i < 24; i++) begin
      rst_n = vt[i].rst_n; pv0 = vt[i].pv; pd0 = 4'(vt[i].pd); pr0 = vt[i].pr;
      step();
      chk0($sformatf("vec%0d", i), vt[i].cnt, vt[i].head);
    end
    rst_n = 1'b1; pv0 = 0; pr0 = 0;

    // Full queue: push blocked, concurrent pop still happens, 0 never stored.
    for (int v = 15; v >= 8; v--) begin
      pv0 = 1; pd0 = 4'(v);
      step();
    end
    pv0 = 0;
    chk0("filled", 8, 8);
    pv0 = 1; pd0 = 0; pr0 = 1;
    #1;
    chk("full push_ready with push_valid", int'(prdy0), 0);
    step();
    pv0 = 0;
    chk0("full push+pop", 7, 9);
    for (int v = 10; v <= 15; v++) begin
      step();
      chk0($sformatf("drain%0d", v), 15 - v + 1, v);
    end
    step();
    chk0("drained", 0, -1);
    pr0 = 0;

    // Max-at-head instance.
    pv1 = 1; pd1 = 3;  step();
    pd1 = 12; step();
    pd1 = 8;  step();
    pv1 = 0;
    chk("max head", int'(pdat1), 12);
    chk("max count", int'(cnt1), 3);
    pr1 = 1; step(); pr1 = 0;
    chk("max next head", int'(pdat1), 8);
    chk("max count after pop", int'(cnt1), 2);

    // Randomized run against a sorted list; tags track stable tie order.
    for (int c = 0; c < 10000; c++) begin
      int n, p_push, d, idx;
      bit pushf, popf;
      n = mk.size();
      chk("rnd count", int'(cnt0), n);
      chk("rnd pop_valid", int'(pval0), int'(n != 0));
      chk("rnd full", int'(full0), int'(n == 8));
      if (n > 0) chk("rnd head", int'(pdat0), mk[0]);
      p_push = ((c / 500) % 2 == 0) ? 70 : 30;
      pv0 = ($urandom_range(0, 99) < p_push);
      pr0 = ($urandom_range(0, 99) < 50);
      d = $urandom_range(0, 15);
      pd0 = 4'(d);
      pushf = pv0 && (n < 8);
      popf  = pr0 && (n > 0);
      if (popf) begin
        void'(mk.pop_front());
        void'(mt.pop_front());
      end
      if (pushf) begin
        idx = mk.size();
        for (int j = 0; j < mk.size(); j++) begin
          if (mk[j] > d) begin
            idx = j;
            break;
          end
        end
        mk.insert(idx, d);
        mt.insert(idx, c);
      end
      step();
    end
    pv0 = 0; pr0 = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
